pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 9 +
 rtl/pipeline_hazard_ctrl_if.sv | 30 +++
 rtl/pipeline_hazard_ctrl_sat_cnt16.sv | 11 +
 rtl/pipeline_hazard_ctrl.sv | 65 ++++++
 tb/tb_pipeline_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared cpu encodings for hazard FSM states, register index width and multi-cycle bounds
package pipeline_hazard_ctrl_pkg;
    localparam int REG_W = 2;
    localparam int MC_MIN = 2;
    localparam int MC_MAX = 8;
    localparam logic [1:0] RUN = 2'b00;
    localparam logic [1:0] MC_WAIT = 2'b01;
    typedef logic [REG_W-1:0] reg_idx_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID/EX hazard inputs and pipeline control outputs
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;
    logic id_valid;
    reg_idx_t id_rs;
    reg_idx_t id_rt;
    logic id_uses_rs;
    logic id_uses_rt;
    logic id_multi;
    logic ex_mem_read;
    logic ex_reg_write;
    reg_idx_t ex_wdest;
    logic ex_branch_taken;
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_flush;
    logic [2:0] mc_step;
    logic [1:0] hazard_state;
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_multi,
        output ex_mem_read, ex_reg_write, ex_wdest, ex_branch_taken,
        input pc_hold, ifid_hold, ifid_flush, idex_flush, mc_step, hazard_state
    );
    modport slave (
        input id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_multi,
        input ex_mem_read, ex_reg_write, ex_wdest, ex_branch_taken,
        output pc_hold, ifid_hold, ifid_flush, idex_flush, mc_step, hazard_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_cnt16.sv
// sat_cnt16: 16-bit event counter that sticks at 16'hFFFF
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 16'd0;
        else if (inc && q != 16'hFFFF) q <= q + 16'd1;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: branch flush, load-use stall and multi-cycle ID sequencing
// HAZARD_PERF_CNT_EN adds saturating stall_cnt/flush_cnt ports.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MULTI_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);
    generate
        if (MULTI_CYC < MC_MIN || MULTI_CYC > MC_MAX) begin : g_bad_multi_cyc
            $error("MULTI_CYC must be within 2..8");
        end
    endgenerate

    localparam logic [2:0] CNT_LOAD = 3'(MULTI_CYC - 1);

    logic [1:0] state, state_n;
    logic [2:0] cnt, cnt_n, step, step_n;
    logic lu, br, legal, freeze, mc_entry, mc_busy, hold;

    always_comb begin
        lu = bus.id_valid & bus.ex_mem_read & bus.ex_reg_write &
             ((bus.id_uses_rs & (bus.id_rs == bus.ex_wdest)) | (bus.id_uses_rt & (bus.id_rt == bus.ex_wdest)));
        br = bus.ex_branch_taken;
        legal = state == RUN || state == MC_WAIT;
        freeze = lu && legal;
        mc_entry = state == RUN && bus.id_valid && bus.id_multi;
        mc_busy = state == MC_WAIT && cnt > 3'd1;
        hold = !rst && !br && (lu || mc_entry || mc_busy);
        bus.pc_hold = hold;
        bus.ifid_hold = hold;
        bus.ifid_flush = !rst && br;
        bus.idex_flush = !rst && (br || lu);
        state_n = br ? RUN : freeze ? state : (mc_entry || mc_busy) ? MC_WAIT : RUN;
        cnt_n = br ? 3'd0 : freeze ? cnt : mc_entry ? CNT_LOAD : mc_busy ? cnt - 3'd1 : 3'd0;
        step_n = br ? 3'd0 : freeze ? step : mc_entry ? 3'd1 : mc_busy ? step + 3'd1 : 3'd0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= RUN;
            cnt <= 3'd0;
            step <= 3'd0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            step <= step_n;
        end

    assign bus.mc_step = step;
    assign bus.hazard_state = state;

`ifdef HAZARD_PERF_CNT_EN
    sat_cnt16 u_stall_cnt (.clk(clk), .rst(rst), .inc(bus.pc_hold), .q(stall_cnt));
    sat_cnt16 u_flush_cnt (.clk(clk), .rst(rst), .inc(bus.ifid_flush), .q(flush_cnt));
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard control for MULTI_CYC=3 and MULTI_CYC=4
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid, id_uses_rs, id_uses_rt, id_multi, ex_mem_read, ex_reg_write, ex_branch_taken;
    logic [1:0] id_rs, id_rt, ex_wdest;
    int tests = 0;
    int fails = 0;

    pipeline_hazard_ctrl_if h3 ();
    pipeline_hazard_ctrl_if h4 ();

    assign h3.id_valid = id_valid;        assign h4.id_valid = id_valid;
    assign h3.id_rs = id_rs;              assign h4.id_rs = id_rs;
    assign h3.id_rt = id_rt;              assign h4.id_rt = id_rt;
    assign h3.id_uses_rs = id_uses_rs;    assign h4.id_uses_rs = id_uses_rs;
    assign h3.id_uses_rt = id_uses_rt;    assign h4.id_uses_rt = id_uses_rt;
    assign h3.id_multi = id_multi;        assign h4.id_multi = id_multi;
    assign h3.ex_mem_read = ex_mem_read;  assign h4.ex_mem_read = ex_mem_read;
    assign h3.ex_reg_write = ex_reg_write; assign h4.ex_reg_write = ex_reg_write;
    assign h3.ex_wdest = ex_wdest;        assign h4.ex_wdest = ex_wdest;
    assign h3.ex_branch_taken = ex_branch_taken; assign h4.ex_branch_taken = ex_branch_taken;

    wire [3:0] c3 = {h3.pc_hold, h3.ifid_hold, h3.ifid_flush, h3.idex_flush};
    wire [3:0] c4 = {h4.pc_hold, h4.ifid_hold, h4.ifid_flush, h4.idex_flush};

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall3, flush3, stall4, flush4;
    pipeline_hazard_ctrl #(.MULTI_CYC(3)) dut3 (.clk(clk), .rst(rst), .bus(h3), .stall_cnt(stall3), .flush_cnt(flush3));
    pipeline_hazard_ctrl #(.MULTI_CYC(4)) dut4 (.clk(clk), .rst(rst), .bus(h4), .stall_cnt(stall4), .flush_cnt(flush4));
`else
    pipeline_hazard_ctrl #(.MULTI_CYC(3)) dut3 (.clk(clk), .rst(rst), .bus(h3));
    pipeline_hazard_ctrl #(.MULTI_CYC(4)) dut4 (.clk(clk), .rst(rst), .bus(h4));
`endif

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_multi = 0;
        ex_mem_read = 0; ex_reg_write = 0; ex_wdest = 0; ex_branch_taken = 0;
    endtask

    task automatic set_lu();
        id_valid = 1; id_rs = 2; id_uses_rs = 1; ex_mem_read = 1; ex_reg_write = 1; ex_wdest = 2;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        set_lu();
        id_multi = 1;
        ex_branch_taken = 1;
        #2;
        tests++; if (c3 !== 4'b0000) begin fails++; $display("FAIL reset_ctl3 got %b want 0000", c3); end
        tests++; if (c4 !== 4'b0000) begin fails++; $display("FAIL reset_ctl4 got %b want 0000", c4); end
        tick();
        tests++; if (h3.hazard_state !== 2'b00) begin fails++; $display("FAIL reset_state got %b want 00", h3.hazard_state); end
        tests++; if (h3.mc_step !== 3'd0) begin fails++; $display("FAIL reset_step got %0d want 0", h3.mc_step); end
        tests++; if (c3 !== 4'b0000) begin fails++; $display("FAIL reset_ctl3_held got %b want 0000", c3); end
        idle();
        rst = 0;
        #1;
        tests++; if (c3 !== 4'b0000) begin fails++; $display("FAIL idle_ctl got %b want 0000", c3); end
    endtask

    task automatic test_load_use();
        tick();
        idle();
        set_lu();
        #1;
        tests++; if (c3 !== 4'b1101) begin fails++; $display("FAIL lu_stall got %b want 1101", c3); end
        tick();
        ex_mem_read = 0;
        ex_reg_write = 0;
        #1;
        tests++; if (c3 !== 4'b0000) begin fails++; $display("FAIL lu_bubble got %b want 0000", c3); end
        tests++; if (h3.hazard_state !== 2'b00) begin fails++; $display("FAIL lu_state got %b want 00", h3.hazard_state); end
    endtask

    task automatic test_no_false_lu();
        tick();
        idle();
        set_lu();
        id_uses_rs = 0;
        id_rt = 1;
        id_uses_rt = 1;
        #1;
        tests++; if (c3 !== 4'b0000) begin fails++; $display("FAIL no_false_lu got %b want 0000", c3); end
        id_rt = 2;
        #1;
        tests++; if (c3 !== 4'b1101) begin fails++; $display("FAIL lu_rt got %b want 1101", c3); end
        tick();
        idle();
    endtask

    task automatic test_multi();
        tick();
        idle();
        id_valid = 1;
        id_multi = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (c3 !== ((i < 2) ? 4'b1100 : 4'b0000)) begin fails++; $display("FAIL multi_ctl[%0d] got %b", i, c3); end
            tests++; if (h3.mc_step !== 3'(i)) begin fails++; $display("FAIL multi_step[%0d] got %0d want %0d", i, h3.mc_step, i); end
            tests++; if (h3.hazard_state !== ((i == 0) ? 2'b00 : 2'b01)) begin fails++; $display("FAIL multi_state[%0d] got %b", i, h3.hazard_state); end
            tick();
        end
        idle();
        #1;
        tests++; if (h3.hazard_state !== 2'b00 || h3.mc_step !== 3'd0) begin fails++; $display("FAIL multi_done got %b/%0d want 00/0", h3.hazard_state, h3.mc_step); end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        id_valid = 1;
        id_multi = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++; if (h3.mc_step !== 3'(i % 3) || h3.pc_hold !== (i % 3 != 2)) begin
                fails++; $display("FAIL b2b[%0d] got step %0d hold %b want step %0d hold %b", i, h3.mc_step, h3.pc_hold, i % 3, i % 3 != 2);
            end
            tick();
        end
        idle();
        tick(); tick(); tick();
    endtask

    task automatic test_branch_mc();
        idle();
        id_valid = 1;
        id_multi = 1;
        #1;
        tests++; if (c4 !== 4'b1100) begin fails++; $display("FAIL br_mc_entry got %b want 1100", c4); end
        tick();
        tests++; if (h4.mc_step !== 3'd1 || h4.hazard_state !== 2'b01) begin fails++; $display("FAIL br_mc_pre got %0d/%b want 1/01", h4.mc_step, h4.hazard_state); end
        ex_branch_taken = 1;
        #1;
        tests++; if (c4 !== 4'b0011) begin fails++; $display("FAIL br_mc_flush got %b want 0011", c4); end
        tick();
        idle();
        #1;
        tests++; if (h4.hazard_state !== 2'b00 || h4.mc_step !== 3'd0 || c4 !== 4'b0000) begin
            fails++; $display("FAIL br_mc_after got %b/%0d/%b want 00/0/0000", h4.hazard_state, h4.mc_step, c4);
        end
        tick();
    endtask

    task automatic test_lu_in_mc();
        idle();
        id_valid = 1;
        id_multi = 1;
        tick();
        set_lu();
        #1;
        tests++; if (c3 !== 4'b1101) begin fails++; $display("FAIL mc_lu got %b want 1101", c3); end
        tick();
        tests++; if (h3.mc_step !== 3'd1 || h3.hazard_state !== 2'b01) begin fails++; $display("FAIL mc_lu_freeze got %0d/%b want 1/01", h3.mc_step, h3.hazard_state); end
        ex_mem_read = 0;
        ex_reg_write = 0;
        #1;
        tests++; if (c3 !== 4'b1100) begin fails++; $display("FAIL mc_lu_resume got %b want 1100", c3); end
        tick();
        tests++; if (h3.mc_step !== 3'd2 || c3 !== 4'b0000) begin fails++; $display("FAIL mc_lu_last got %0d/%b want 2/0000", h3.mc_step, c3); end
        idle();
        tick(); tick(); tick();
    endtask

    task automatic test_branch_lu();
        idle();
        set_lu();
        ex_branch_taken = 1;
        #1;
        tests++; if (c3 !== 4'b0011) begin fails++; $display("FAIL br_lu got %b want 0011", c3); end
        tick();
        idle();
        #1;
        tests++; if (c3 !== 4'b0000 || h3.hazard_state !== 2'b00) begin fails++; $display("FAIL br_lu_after got %b/%b want 0000/00", c3, h3.hazard_state); end
    endtask

    task automatic test_reset_mid_mc();
        tick();
        idle();
        id_valid = 1;
        id_multi = 1;
        tick();
        tick();
        tests++; if (h4.mc_step !== 3'd2) begin fails++; $display("FAIL rst_mc_pre got %0d want 2", h4.mc_step); end
        rst = 1;
        #1;
        tests++; if (h4.hazard_state !== 2'b00 || h4.mc_step !== 3'd0 || c4 !== 4'b0000) begin
            fails++; $display("FAIL rst_mc got %b/%0d/%b want 00/0/0000", h4.hazard_state, h4.mc_step, c4);
        end
        tick();
        idle();
        rst = 0;
        #1;
        tests++; if (h4.hazard_state !== 2'b00 || c4 !== 4'b0000) begin fails++; $display("FAIL rst_mc_after got %b/%b want 00/0000", h4.hazard_state, c4); end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        tick();
        rst = 1;
        idle();
        #1;
        tests++; if (stall3 !== 16'd0 || flush3 !== 16'd0) begin fails++; $display("FAIL perf_reset got %0d/%0d want 0/0", stall3, flush3); end
        tick();
        rst = 0;
        ex_branch_taken = 1;
        tick();
        tick();
        ex_branch_taken = 0;
        #1;
        tests++; if (flush3 !== 16'd2) begin fails++; $display("FAIL perf_flush got %0d want 2", flush3); end
        set_lu();
        for (int i = 0; i < 70000; i++) tick();
        idle();
        #1;
        tests++; if (stall3 !== 16'hFFFF) begin fails++; $display("FAIL perf_sat got %h want ffff", stall3); end
        tick();
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_no_false_lu();
        test_multi();
        test_back_to_back();
        test_branch_mc();
        test_lu_in_mc();
        test_branch_lu();
        test_reset_mid_mc();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
